// File: rtl/dpc_insn_pkg.sv
// Shared opcodes, FSM states and scan modes for the instruction fetch controller.
package dpc_insn_pkg;

    localparam logic [3:0] NOP        = 4'h0;
    localparam logic [3:0] LOOP_OPEN  = 4'h7;
    localparam logic [3:0] LOOP_CLOSE = 4'h8;
    localparam logic [3:0] HALT       = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALTED,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        NORMAL,
        SCAN_FWD,
        SCAN_BACK
    } mode_e;

endpackage

// File: rtl/ip_counter.sv
// Instruction pointer register: clear, increment, decrement, with edge flags.
module ip_counter #(
    parameter int unsigned AddressSize = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   clr,
    input  logic                   inc,
    input  logic                   dec,
    output logic [AddressSize-1:0] ip,
    output logic                   wrap_c,
    output logic                   underflow_c
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ip <= '0;
        end else if (clr) begin
            ip <= '0;
        end else if (inc) begin
            ip <= ip + AddressSize'(1);
        end else if (dec) begin
            ip <= ip - AddressSize'(1);
        end
    end

    // An increment from all-ones wraps; a decrement from zero underflows.
    assign wrap_c      = &ip;
    assign underflow_c = ~|ip;

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Fetch/issue controller with bracket-matching scans over a registered ROM.
// Optional single-step gating of issue is enabled with `define SINGLE_STEP_EN.
module insn_fetch_ctrl
    import dpc_insn_pkg::*;
#(
    parameter int unsigned AddressSize = 16,
    parameter int unsigned DepthSize   = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
`ifdef SINGLE_STEP_EN
    input  logic                   Step,
`endif
    output logic [AddressSize-1:0] RomAddress,
    input  logic [3:0]             RomInsn,
    output logic [3:0]             Insn,
    output logic                   InsnValid,
    input  logic                   InsnReady,
    input  logic                   DataZero,
    output logic [AddressSize-1:0] Ip,
    output logic                   Busy,
    output logic                   Halted,
    output logic                   Error
);

    state_e                 state;
    mode_e                  mode;
    logic [DepthSize-1:0]   depth;
    logic [DepthSize-1:0]   depth_next_c;
    logic                   depth_ovf_c;
    logic                   scan_done_c;
    logic                   scan_step_back_c;
    logic                   scan_err_c;
    logic                   handshake_c;
    logic                   hs_open_c;
    logic                   hs_close_c;
    logic                   hs_err_c;
    logic                   ip_clr_c;
    logic                   ip_inc_c;
    logic                   ip_dec_c;
    logic                   ip_wrap_c;
    logic                   ip_under_c;
    logic                   step_pending;

    ip_counter #(
        .AddressSize(AddressSize)
    ) u_ip (
        .Clk         (Clk),
        .Rst         (Rst),
        .clr         (ip_clr_c),
        .inc         (ip_inc_c),
        .dec         (ip_dec_c),
        .ip          (Ip),
        .wrap_c      (ip_wrap_c),
        .underflow_c (ip_under_c)
    );

    assign RomAddress = Ip;

`ifdef SINGLE_STEP_EN
    // A Step pulse arms one issue; the handshake consumes it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            step_pending <= 1'b0;
        end else if (Step) begin
            step_pending <= 1'b1;
        end else if (handshake_c) begin
            step_pending <= 1'b0;
        end
    end
`else
    assign step_pending = 1'b1;
`endif

    assign handshake_c = InsnValid & InsnReady;
    assign hs_open_c   = (Insn == LOOP_OPEN)  &  DataZero;
    assign hs_close_c  = (Insn == LOOP_CLOSE) & ~DataZero;
    // Starting a scan must not itself step off either end of the address space.
    assign hs_err_c    = (hs_open_c & ip_wrap_c) | (hs_close_c & ip_under_c);

    // Bracket depth tracking for the word currently returned by the ROM.
    always_comb begin
        depth_next_c = depth;
        depth_ovf_c  = 1'b0;
        if (((mode == SCAN_FWD) && (RomInsn == LOOP_OPEN)) ||
            ((mode == SCAN_BACK) && (RomInsn == LOOP_CLOSE))) begin
            depth_ovf_c  = &depth;
            depth_next_c = depth + DepthSize'(1);
        end else if (((mode == SCAN_FWD) && (RomInsn == LOOP_CLOSE)) ||
                     ((mode == SCAN_BACK) && (RomInsn == LOOP_OPEN))) begin
            depth_next_c = depth - DepthSize'(1);
        end
        scan_done_c      = (depth_next_c == '0);
        scan_step_back_c = (mode == SCAN_BACK) && !scan_done_c;
        scan_err_c       = depth_ovf_c ||
                           (scan_step_back_c ? ip_under_c
                                             : ((mode == SCAN_FWD) && ip_wrap_c));
    end

    // Instruction pointer commands, decoded from the same conditions as the FSM.
    always_comb begin
        ip_clr_c = 1'b0;
        ip_inc_c = 1'b0;
        ip_dec_c = 1'b0;
        case (state)
            IDLE, HALTED: ip_clr_c = Start;
            WAIT: begin
                if ((mode != NORMAL) && !scan_err_c) begin
                    ip_dec_c = scan_step_back_c;
                    ip_inc_c = !scan_step_back_c;
                end
            end
            ISSUE: begin
                if (handshake_c && (Insn != HALT) && !hs_err_c) begin
                    ip_dec_c = hs_close_c;
                    ip_inc_c = !hs_close_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            mode      <= NORMAL;
            depth     <= '0;
            Insn      <= NOP;
            InsnValid <= 1'b0;
            Busy      <= 1'b0;
            Halted    <= 1'b0;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (Start) begin
                        state  <= FETCH;
                        mode   <= NORMAL;
                        depth  <= '0;
                        Busy   <= 1'b1;
                        Halted <= 1'b0;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    if (mode == NORMAL) begin
                        Insn      <= RomInsn;
                        InsnValid <= step_pending;
                        state     <= ISSUE;
                    end else if (scan_err_c) begin
                        state <= ERROR;
                        Busy  <= 1'b0;
                        Error <= 1'b1;
                    end else begin
                        depth <= depth_next_c;
                        state <= FETCH;
                        if (scan_done_c) begin
                            mode <= NORMAL;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake_c) begin
                        InsnValid <= 1'b0;
                        if (Insn == HALT) begin
                            state  <= HALTED;
                            Busy   <= 1'b0;
                            Halted <= 1'b1;
                        end else if (hs_err_c) begin
                            state <= ERROR;
                            Busy  <= 1'b0;
                            Error <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (hs_open_c) begin
                                depth <= DepthSize'(1);
                                mode  <= SCAN_FWD;
                            end else if (hs_close_c) begin
                                depth <= DepthSize'(1);
                                mode  <= SCAN_BACK;
                            end
                        end
                    end else begin
                        InsnValid <= step_pending;
                    end
                end
                ERROR: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Directed bench for insn_fetch_ctrl with a registered ROM model.
module tb_insn_fetch_ctrl;
    import dpc_insn_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Start;
`ifdef SINGLE_STEP_EN
    logic        Step;
`endif
    logic [15:0] RomAddress;
    logic [3:0]  RomInsn;
    logic [3:0]  Insn;
    logic        InsnValid;
    logic        InsnReady;
    logic        DataZero;
    logic [15:0] Ip;
    logic        Busy;
    logic        Halted;
    logic        Error;

    logic [3:0]  rom [0:65535];
    logic [15:0] hs_ips [$];
    int          total;
    int          bad;
    logic        stable;

    insn_fetch_ctrl #(
        .AddressSize(16),
        .DepthSize  (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
`ifdef SINGLE_STEP_EN
        .Step      (Step),
`endif
        .RomAddress(RomAddress),
        .RomInsn   (RomInsn),
        .Insn      (Insn),
        .InsnValid (InsnValid),
        .InsnReady (InsnReady),
        .DataZero  (DataZero),
        .Ip        (Ip),
        .Busy      (Busy),
        .Halted    (Halted),
        .Error     (Error)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One-cycle registered ROM.
    always @(posedge Clk) RomInsn <= rom[RomAddress];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Logs any handshake pending at this edge, then advances one cycle.
    task automatic tick();
        if (InsnValid === 1'b1 && InsnReady === 1'b1) hs_ips.push_back(Ip);
        @(posedge Clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 65536; i++) rom[i] = NOP;
    endtask

    task automatic do_reset();
        Rst       = 1'b1;
        Start     = 1'b0;
        InsnReady = 1'b0;
        DataZero  = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        hs_ips.delete();
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic run_until_stop(input int budget);
        for (int i = 0; i < budget && Halted !== 1'b1 && Error !== 1'b1; i++) tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        Rst       = 1'b1;
        Start     = 1'b0;
        InsnReady = 1'b0;
        DataZero  = 1'b0;
`ifdef SINGLE_STEP_EN
        Step      = 1'b1;
`endif
        rom_clear();

        // Reset state
        do_reset();
        check("rst_valid",  32'(InsnValid), 32'd0);
        check("rst_insn",   32'(Insn),      32'h0);
        check("rst_ip",     32'(Ip),        32'h0);
        check("rst_busy",   32'(Busy),      32'd0);
        check("rst_halted", 32'(Halted),    32'd0);
        check("rst_error",  32'(Error),     32'd0);

        // NOP, NOP, HALT with core always ready
        rom[0] = NOP; rom[1] = NOP; rom[2] = HALT;
        InsnReady = 1'b1;
        pulse_start();
        check("lat_c1_valid", 32'(InsnValid), 32'd0);
        check("lat_c1_busy",  32'(Busy),      32'd1);
        tick();
        check("lat_c2_valid", 32'(InsnValid), 32'd0);
        tick();
        check("lat_c3_valid", 32'(InsnValid), 32'd1);
        check("lat_c3_insn",  32'(Insn),      32'(NOP));
        run_until_stop(40);
        check("halt_flag",  32'(Halted),        32'd1);
        check("halt_busy",  32'(Busy),          32'd0);
        check("halt_hs",    32'(hs_ips.size()), 32'd3);
        check("halt_ip",    32'(Ip),            32'd2);
        check("halt_insn",  32'(Insn),          32'(HALT));
        pulse_start();
        check("restart_busy",   32'(Busy),   32'd1);
        check("restart_halted", 32'(Halted), 32'd0);
        check("restart_ip",     32'(Ip),     32'd0);

        // Stalled core: offered instruction held stable
        do_reset();
        rom_clear();
        rom[0] = 4'h3; rom[1] = HALT;
        pulse_start();
        tick();
        tick();
        check("stall_valid", 32'(InsnValid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (InsnValid !== 1'b1 || Insn !== 4'h3) stable = 1'b0;
        end
        check("stall_stable", 32'(stable),        32'd1);
        check("stall_no_hs",  32'(hs_ips.size()), 32'd0);
        InsnReady = 1'b1;
        run_until_stop(40);
        check("stall_hs", 32'(hs_ips.size()), 32'd2);

        // Forward scan over nested brackets
        do_reset();
        rom_clear();
        rom[0] = LOOP_OPEN; rom[1] = NOP; rom[2] = LOOP_OPEN;
        rom[3] = LOOP_CLOSE; rom[4] = LOOP_CLOSE; rom[5] = HALT;
        InsnReady = 1'b1;
        DataZero  = 1'b1;
        pulse_start();
        run_until_stop(80);
        check("fwd_halted", 32'(Halted),        32'd1);
        check("fwd_hs_n",   32'(hs_ips.size()), 32'd2);
        if (hs_ips.size() == 2) begin
            check("fwd_hs0_ip", 32'(hs_ips[0]), 32'd0);
            check("fwd_hs1_ip", 32'(hs_ips[1]), 32'd5);
        end
        check("fwd_ip", 32'(Ip), 32'd5);

        // Backward scan from address 4 to its LOOP_OPEN at address 1
        do_reset();
        rom_clear();
        rom[0] = NOP; rom[1] = LOOP_OPEN; rom[2] = NOP; rom[3] = NOP;
        rom[4] = LOOP_CLOSE; rom[5] = HALT;
        InsnReady = 1'b1;
        DataZero  = 1'b0;
        pulse_start();
        for (int i = 0; i < 100 && hs_ips.size() < 6; i++) tick();
        check("back_hs_n6", 32'(hs_ips.size()), 32'd6);
        if (hs_ips.size() == 6) begin
            check("back_close_ip", 32'(hs_ips[4]), 32'd4);
            check("back_next_ip",  32'(hs_ips[5]), 32'd2);
        end
        DataZero = 1'b1;
        run_until_stop(80);
        check("back_halted", 32'(Halted),        32'd1);
        check("back_hs_n",   32'(hs_ips.size()), 32'd9);
        check("back_ip",     32'(Ip),            32'd5);

        // Unmatched LOOP_OPEN near the top of memory
        do_reset();
        rom_clear();
        rom[16'hFFF0] = LOOP_OPEN;
        InsnReady = 1'b1;
        DataZero  = 1'b1;
        pulse_start();
        // Jump the pointer to 0xFFF0 while the DUT sits in FETCH.
        force dut.u_ip.ip = 16'hFFF0;
        tick();
        release dut.u_ip.ip;
        check("top_ip_loaded", 32'(Ip), 32'hFFF0);
        run_until_stop(100);
        check("top_error",  32'(Error),         32'd1);
        check("top_busy",   32'(Busy),          32'd0);
        check("top_ip",     32'(Ip),            32'hFFFF);
        check("top_hs_n",   32'(hs_ips.size()), 32'd1);
        pulse_start();
        tick();
        check("err_sticky", 32'(Error), 32'd1);
        check("err_nobusy", 32'(Busy),  32'd0);
        check("err_ip",     32'(Ip),    32'hFFFF);

        // Reset in the middle of a forward scan
        do_reset();
        check("rst_clears_error", 32'(Error), 32'd0);
        rom_clear();
        rom[0] = LOOP_OPEN;
        InsnReady = 1'b1;
        DataZero  = 1'b1;
        pulse_start();
        for (int i = 0; i < 20 && hs_ips.size() < 1; i++) tick();
        tick();
        tick();
        check("scan_busy",  32'(Busy),      32'd1);
        check("scan_valid", 32'(InsnValid), 32'd0);
        Rst = 1'b1;
        tick();
        check("mid_rst_valid",  32'(InsnValid),  32'd0);
        check("mid_rst_insn",   32'(Insn),       32'h0);
        check("mid_rst_ip",     32'(Ip),         32'h0);
        check("mid_rst_addr",   32'(RomAddress), 32'h0);
        check("mid_rst_busy",   32'(Busy),       32'd0);
        check("mid_rst_halted", 32'(Halted),     32'd0);
        check("mid_rst_error",  32'(Error),      32'd0);
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_idle_hs", 32'(hs_ips.size()), 32'd1);
        check("mid_rst_idle",    32'(Busy),          32'd0);

`ifdef SINGLE_STEP_EN
        // Single-step gating
        do_reset();
        rom_clear();
        rom[0] = NOP; rom[1] = HALT;
        Step      = 1'b0;
        InsnReady = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        check("step_none_valid", 32'(InsnValid),     32'd0);
        check("step_none_hs",    32'(hs_ips.size()), 32'd0);
        Step = 1'b1;
        tick();
        Step = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("step_one_hs",    32'(hs_ips.size()), 32'd1);
        check("step_one_valid", 32'(InsnValid),     32'd0);
        check("step_one_ip",    32'(Ip),            32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/insn_fetch_ctrl.md
INSN_FETCH_CTRL -- requirements
Module: insn_fetch_ctrl

Interface
REQ-001 SHALL have parameter AddressSize, default 16, meaning the width of the instruction pointer and ROM address.
REQ-002 SHALL have parameter DepthSize, default 8, meaning the width of the bracket nesting counter.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1 bit: begins execution at address 0.
REQ-006 SHALL have port RomAddress, output, AddressSize bits: ROM read address, equal to Ip.
REQ-007 SHALL have port RomInsn, input, 4 bits: registered ROM data, valid one cycle after RomAddress.
REQ-008 SHALL have port Insn, output, 4 bits: the issued instruction (registered).
REQ-009 SHALL have port InsnValid, output, 1 bit: Insn is offered to the core.
REQ-010 SHALL have port InsnReady, input, 1 bit: the core accepts Insn; a handshake occurs when InsnValid and InsnReady are both 1.
REQ-011 SHALL have port DataZero, input, 1 bit: the core's current data cell is zero; sampled only at a handshake.
REQ-012 SHALL have port Ip, output, AddressSize bits: the current instruction pointer.
REQ-013 SHALL have ports Busy, Halted and Error, each output, 1 bit: status flags.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT, ISSUE, HALTED and ERROR, plus a Mode register with values NORMAL, SCAN_FWD and SCAN_BACK.
REQ-015 SHALL accept Start only in IDLE or HALTED: Ip := 0, Mode := NORMAL, then go to FETCH; Start is ignored in all other states.
REQ-016 SHALL go FETCH -> WAIT unconditionally; RomInsn is sampled in WAIT.
REQ-017 SHALL, in WAIT with Mode NORMAL, latch RomInsn into Insn and go to ISSUE, so that InsnValid rises exactly 3 cycles after Start is sampled.
REQ-018 SHALL hold InsnValid and Insn stable in ISSUE until the handshake.
REQ-019 SHALL handle a handshake on HALT by going to HALTED with Ip unchanged.
REQ-020 SHALL handle a handshake on LOOP_OPEN with DataZero=1 by setting Depth := 1, Ip := Ip+1, Mode := SCAN_FWD, and going to FETCH.
REQ-021 SHALL handle a handshake on LOOP_CLOSE with DataZero=0 by setting Depth := 1, Ip := Ip-1, Mode := SCAN_BACK, and going to FETCH.
REQ-022 SHALL handle any other handshake by setting Ip := Ip+1 (wrapping from max to 0 in NORMAL mode) and going to FETCH.
REQ-023 SHALL, in WAIT with Mode SCAN_FWD, increment Depth on LOOP_OPEN and decrement it on LOOP_CLOSE; if Depth reaches 0: Mode := NORMAL, Ip := Ip+1; otherwise Ip := Ip+1; then go to FETCH; no instruction is issued during a scan.
REQ-024 SHALL, in WAIT with Mode SCAN_BACK, increment Depth on LOOP_CLOSE and decrement it on LOOP_OPEN; if Depth reaches 0: Mode := NORMAL, Ip := Ip+1; otherwise Ip := Ip-1; then go to FETCH.
REQ-025 SHALL go to ERROR if a scan must step past address max (SCAN_FWD) or below 0 (SCAN_BACK), or if Depth would overflow.
REQ-026 SHALL make ERROR sticky: it is left only by Rst.
REQ-027 SHALL drive Busy=1 in FETCH, WAIT and ISSUE, Halted=1 in HALTED, and Error=1 in ERROR.

Reset
REQ-028 SHALL, when Rst=1 at a clock edge, set state IDLE, Mode NORMAL, Ip=0, Depth=0, Insn=4'h0, and InsnValid, Busy, Halted and Error all 0.
REQ-029 SHALL give Rst priority over Start and the handshake; an assertion mid-scan or mid-issue abandons the operation without emitting a handshake.

Configuration
REQ-030 SHALL, when SINGLE_STEP_EN is defined, add input port Step (1 bit); a Step pulse sets StepPending, ISSUE asserts InsnValid only while StepPending=1, and the handshake clears StepPending.
REQ-031 SHALL, when SINGLE_STEP_EN is undefined, omit Step and behave as if StepPending were always 1.

Structure
REQ-032 SHALL place the opcode constants (NOP=4'h0, LOOP_OPEN=4'h7, LOOP_CLOSE=4'h8, HALT=4'hF) and the state and Mode enums in package dpc_insn_pkg.
REQ-033 SHALL implement Ip as sub-module ip_counter: load-zero, increment and decrement, with an AddressSize-bit wrap/underflow flag.

Verification
REQ-034 SHALL verify: Start with ROM {NOP,NOP,HALT} and InsnReady=1 -> InsnValid rises 3 cycles after Start, three handshakes occur, then Halted=1 and Ip=2.
REQ-035 SHALL verify: ROM {LOOP_OPEN,NOP,LOOP_OPEN,LOOP_CLOSE,LOOP_CLOSE,HALT} with DataZero=1 at address 0 -> next issued Ip=5 (HALT), and no instructions 1-4 are issued.
REQ-036 SHALL verify: LOOP_CLOSE at address 4 with DataZero=0 and its matching LOOP_OPEN at address 1 -> next issued Ip=2.
REQ-037 SHALL verify: an unmatched LOOP_OPEN at address 0xFFF0 with DataZero=1 -> Error=1 after the scan reaches 0xFFFF, and a subsequent Start is ignored.
REQ-038 SHALL verify: InsnReady held 0 for 10 cycles -> Insn and InsnValid remain stable; Rst asserted during SCAN_FWD -> all outputs return to reset values on the next edge.
REQ-039 SHALL verify, with SINGLE_STEP_EN defined: no Step input -> InsnValid stays 0; one Step pulse -> exactly one handshake occurs.
